// File: rtl/auto_baud_detect.sv
// Auto-baud detector: times low pulses of a 0x55 sync character on the rx line
// and, once NUM_PULSES consecutive pulses classify alike, locks the baud select code.
module auto_baud_detect #(
  parameter int CNT_W      = 13,
  parameter int IDLE_MIN   = 6000,
  parameter int MIN_BIT    = 300,
  parameter int MAX_BIT    = 6500,
  parameter int TH_19200   = 3906,
  parameter int TH_38400   = 1953,
  parameter int TH_57600   = 1085,
  parameter int TH_115200  = 651,
  parameter int NUM_PULSES = 4,
  parameter int GAP_MAX    = 6500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       restart,
  output logic [2:0] bc,
  output logic       locked,
  output logic       bc_valid,
  output logic       err,
  output logic [2:0] state_dbg
);

  localparam int MW = $clog2(NUM_PULSES + 1);

  localparam logic [CNT_W-1:0] IDLE_C  = CNT_W'(IDLE_MIN);
  localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(MIN_BIT);
  localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_BIT);
  localparam logic [CNT_W-1:0] TH0_C   = CNT_W'(TH_19200);
  localparam logic [CNT_W-1:0] TH1_C   = CNT_W'(TH_38400);
  localparam logic [CNT_W-1:0] TH2_C   = CNT_W'(TH_57600);
  localparam logic [CNT_W-1:0] TH3_C   = CNT_W'(TH_115200);
  localparam logic [CNT_W-1:0] GAP_C   = CNT_W'(GAP_MAX);
  localparam logic [CNT_W-1:0] CNT_TOP = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [MW-1:0]    M_LOCK  = MW'(NUM_PULSES);
  localparam logic [MW-1:0]    M_ONE   = MW'(1);

  typedef enum logic [2:0] {
    IDLE_WAIT = 3'd0,
    ARMED     = 3'd1,
    MEASURE   = 3'd2,
    CHECK     = 3'd3,
    GAP       = 3'd4,
    LOCKED    = 3'd5
  } state_t;

  state_t state, state_next;

  logic rx_s1, rx_s2, rx_d;
  logic fall, rise;

  logic [CNT_W-1:0] idle_cnt, width, gap_cnt;
  logic [MW-1:0]    match, match_new;
  logic [2:0]       prev, code;
  logic             width_bad, same, lock_hit, gap_over, err_next, bcv_next;

  assign state_dbg = state;

  // Synchronizer plus one history stage; all presets high so reset never looks like an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  assign fall = rx_d & ~rx_s2;
  assign rise = ~rx_d & rx_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE_WAIT;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (restart) begin
      state_next = IDLE_WAIT;
    end else begin
      case (state)
        IDLE_WAIT: if (idle_cnt == IDLE_C) state_next = ARMED;
        ARMED:     if (fall) state_next = MEASURE;
        MEASURE:   if (rise) state_next = CHECK;
        CHECK: begin
          if (width_bad)     state_next = IDLE_WAIT;
          else if (lock_hit) state_next = LOCKED;
          else               state_next = GAP;
        end
        GAP: begin
          if (fall)          state_next = MEASURE;
          else if (gap_over) state_next = ARMED;
        end
        LOCKED:    state_next = LOCKED;
        default:   state_next = IDLE_WAIT;
      endcase
    end
  end

  // Pulse classification and the registered-output decisions for this cycle.
  always_comb begin
    code = 3'd4;
    if (width >= TH0_C)      code = 3'd0;
    else if (width >= TH1_C) code = 3'd1;
    else if (width >= TH2_C) code = 3'd2;
    else if (width >= TH3_C) code = 3'd3;

    width_bad = (width < MIN_C) || (width > MAX_C);
    same      = (match == '0) || (code == prev);
    match_new = same ? (match + M_ONE) : M_ONE;
    lock_hit  = (state == CHECK) && !width_bad && (match_new == M_LOCK);
    gap_over  = (state == GAP) && !fall && (gap_cnt > GAP_C);
    err_next  = !restart && (((state == CHECK) && (width_bad || !same)) || gap_over);
    bcv_next  = lock_hit && !restart;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
      width    <= '0;
      gap_cnt  <= '0;
      match    <= '0;
      prev     <= 3'd0;
      bc       <= 3'd0;
      locked   <= 1'b0;
      bc_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      err      <= err_next;
      bc_valid <= bcv_next;
      if (bcv_next) begin
        bc     <= code;
        locked <= 1'b1;
      end
      if (restart) begin
        locked   <= 1'b0;
        match    <= '0;
        idle_cnt <= '0;
      end else begin
        case (state)
          IDLE_WAIT: begin
            if (!rx_s2)                 idle_cnt <= '0;
            else if (idle_cnt != CNT_TOP) idle_cnt <= idle_cnt + CNT_ONE;
          end
          ARMED: if (fall) width <= CNT_ONE;
          MEASURE: begin
            if (!rx_s2 && (width != CNT_TOP)) width <= width + CNT_ONE;
          end
          CHECK: begin
            gap_cnt  <= '0;
            idle_cnt <= '0;
            if (width_bad) begin
              match <= '0;
            end else begin
              match <= match_new;
              prev  <= code;
            end
          end
          GAP: begin
            if (fall) begin
              width   <= CNT_ONE;
              gap_cnt <= '0;
            end else if (gap_over) begin
              match <= '0;
            end else if (rx_s2 && (gap_cnt != CNT_TOP)) begin
              gap_cnt <= gap_cnt + CNT_ONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_auto_baud_detect.sv
// Bench for auto_baud_detect. All timing parameters are scaled by 1/8 (and CNT_W
// narrowed to 10) so every scenario fits a short run; bit widths scale the same way.
module tb_auto_baud_detect;

  localparam int IDLE_T = 800;   // comfortably above IDLE_MIN=750 plus sync delay
  localparam int GAP_T  = 60;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       restart = 1'b0;
  logic [2:0] bc;
  logic       locked, bc_valid, err;
  logic [2:0] state_dbg;

  int n_checks = 0;
  int n_err    = 0;
  int bcv_total = 0;
  int err_total = 0;
  int bad_total = 0;

  typedef struct {
    int         w;
    logic [2:0] exp_bc;
    logic       exp_lock;
    int         exp_err;
  } vec_t;

  vec_t vecs[15];

  always #5 clk = ~clk;

  auto_baud_detect #(
    .CNT_W(10), .IDLE_MIN(750), .MIN_BIT(38), .MAX_BIT(812),
    .TH_19200(488), .TH_38400(244), .TH_57600(136), .TH_115200(81),
    .NUM_PULSES(4), .GAP_MAX(812)
  ) dut (
    .clk(clk), .rst(rst), .rx(rx), .restart(restart),
    .bc(bc), .locked(locked), .bc_valid(bc_valid), .err(err),
    .state_dbg(state_dbg)
  );

  always @(negedge clk) begin
    if (bc_valid) bcv_total++;
    if (err) err_total++;
    if ((bc_valid && err) || (bc_valid && !locked)) bad_total++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic hold_rx(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int w, input int g);
    hold_rx(1'b0, w);
    hold_rx(1'b1, g);
  endtask

  task automatic send_55(input int t);
    logic [7:0] d;
    d = 8'h55;
    hold_rx(1'b0, t);
    for (int i = 0; i < 8; i++) hold_rx(d[i], t);
    hold_rx(1'b1, t);
  endtask

  task automatic do_restart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    hold_rx(1'b1, IDLE_T);
  endtask

  initial begin
    int e0, v0;
    logic found;

    vecs[0]  = '{54,  3'd4, 1'b1, 0};
    vecs[1]  = '{109, 3'd3, 1'b1, 0};
    vecs[2]  = '{163, 3'd2, 1'b1, 0};
    vecs[3]  = '{488, 3'd0, 1'b1, 0};
    vecs[4]  = '{487, 3'd1, 1'b1, 0};
    vecs[5]  = '{244, 3'd1, 1'b1, 0};
    vecs[6]  = '{243, 3'd2, 1'b1, 0};
    vecs[7]  = '{136, 3'd2, 1'b1, 0};
    vecs[8]  = '{135, 3'd3, 1'b1, 0};
    vecs[9]  = '{81,  3'd3, 1'b1, 0};
    vecs[10] = '{80,  3'd4, 1'b1, 0};
    vecs[11] = '{812, 3'd0, 1'b1, 0};
    vecs[12] = '{38,  3'd4, 1'b1, 0};
    vecs[13] = '{37,  3'd4, 1'b0, 1};
    vecs[14] = '{813, 3'd4, 1'b0, 1};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_bc", bc, 0);
    check("rst_locked", locked, 0);
    check("rst_bc_valid", bc_valid, 0);
    check("rst_err", err, 0);
    check("rst_state", state_dbg, 0);
    rst = 1'b0;

    // Nominal 9600 sync character after a long idle
    hold_rx(1'b1, 875);
    e0 = err_total; v0 = bcv_total;
    send_55(651);
    hold_rx(1'b1, GAP_T);
    check("s1_locked", locked, 1);
    check("s1_bc", bc, 0);
    check("s1_bc_valid_count", bcv_total - v0, 1);
    check("s1_err_count", err_total - e0, 0);

    // Table: four equal pulses per row, thresholds and accept limits at their edges
    foreach (vecs[i]) begin
      do_restart();
      e0 = err_total; v0 = bcv_total;
      for (int p = 0; p < 4; p++) pulse(vecs[i].w, GAP_T);
      check($sformatf("vec%0d_w%0d_locked", i, vecs[i].w), locked, vecs[i].exp_lock);
      check($sformatf("vec%0d_w%0d_bc", i, vecs[i].w), bc, vecs[i].exp_bc);
      check($sformatf("vec%0d_w%0d_bc_valid_count", i, vecs[i].w), bcv_total - v0, vecs[i].exp_lock ? 1 : 0);
      check($sformatf("vec%0d_w%0d_err_count", i, vecs[i].w), err_total - e0, vecs[i].exp_err);
    end

    // Glitch in the gap between pulses
    do_restart();
    e0 = err_total;
    pulse(163, 163);
    pulse(163, 100);
    pulse(12, 163);
    for (int p = 0; p < 4; p++) pulse(163, 163);
    check("glitch_err_count", err_total - e0, 1);
    check("glitch_no_lock", locked, 0);
    hold_rx(1'b1, IDLE_T);
    send_55(163);
    hold_rx(1'b1, GAP_T);
    check("glitch_relock", locked, 1);
    check("glitch_relock_bc", bc, 2);
    check("glitch_err_total", err_total - e0, 1);

    // Mismatched widths: 19200, 19200, then 38400 pulses
    do_restart();
    e0 = err_total; v0 = bcv_total;
    pulse(326, GAP_T);
    pulse(326, GAP_T);
    pulse(163, GAP_T);
    check("mismatch_err", err_total - e0, 1);
    pulse(163, GAP_T);
    pulse(163, GAP_T);
    check("mismatch_not_yet", locked, 0);
    pulse(163, GAP_T);
    check("mismatch_locked", locked, 1);
    check("mismatch_bc", bc, 2);
    check("mismatch_bc_valid_count", bcv_total - v0, 1);
    check("mismatch_err_total", err_total - e0, 1);

    // Gap timeout drops back to ARMED, which needs no fresh idle period
    do_restart();
    e0 = err_total;
    pulse(163, 1000);
    check("gap_err", err_total - e0, 1);
    check("gap_state_armed", state_dbg, 1);
    for (int p = 0; p < 4; p++) pulse(109, GAP_T);
    check("gap_relock", locked, 1);
    check("gap_relock_bc", bc, 3);

    // Break: line low well past counter saturation
    do_restart();
    e0 = err_total;
    hold_rx(1'b0, 1250);
    hold_rx(1'b1, GAP_T);
    check("break_err", err_total - e0, 1);
    check("break_locked", locked, 0);
    check("break_bc_kept", bc, 3);

    // Restart coinciding with the lock decision
    do_restart();
    send_55(54);
    hold_rx(1'b1, GAP_T);
    check("pre_lock_115200", locked, 1);
    check("pre_lock_bc", bc, 4);
    do_restart();
    v0 = bcv_total;
    for (int p = 0; p < 3; p++) pulse(163, GAP_T);
    hold_rx(1'b0, 163);
    rx = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (state_dbg == 3'd3) begin
        found = 1'b1;
        break;
      end
    end
    check("reach_check_state", found, 1);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    hold_rx(1'b1, GAP_T);
    check("restart_win_locked", locked, 0);
    check("restart_win_bc_kept", bc, 4);
    check("restart_win_no_bc_valid", bcv_total - v0, 0);
    check("restart_win_state", state_dbg, 0);

    // Asynchronous reset in the middle of the fourth pulse
    hold_rx(1'b1, IDLE_T);
    v0 = bcv_total;
    for (int p = 0; p < 3; p++) pulse(163, GAP_T);
    hold_rx(1'b0, 80);
    rst = 1'b1;
    #1;
    check("midrst_bc", bc, 0);
    check("midrst_locked", locked, 0);
    check("midrst_err", err, 0);
    check("midrst_bc_valid", bc_valid, 0);
    check("midrst_state", state_dbg, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    hold_rx(1'b0, 80);
    hold_rx(1'b1, GAP_T);
    pulse(163, GAP_T);
    check("midrst_no_lock", locked, 0);
    check("midrst_no_bc_valid", bcv_total - v0, 0);

    check("bc_valid_err_exclusive", bad_total, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
